// File: rtl/hs_txn_gen.sv
// -----------------------------------------------------------------------------
// hs_txn_gen
//
// Transaction generator feeding the protocol checker. One transaction is:
//   START (a) -> ACK (c, r cleared) -> DONE (d) -> WAIT_GNT -> GRANT (b)
//   -> DATA_BEATS cycles of DATA (c, data_in captured) -> IDLE.
// If no grant arrives within MAX_WAIT WAIT_GNT cycles the transaction is
// dropped and a one-cycle timeout pulse is raised in the following IDLE cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start_req  host request, only looked at in IDLE
//   gnt        arbiter grant, only looked at in WAIT_GNT
//   data_in    data sampled on every DATA beat
//   a          start strobe (START)
//   b          grant-accepted strobe (GRANT)
//   c          ack / data-valid (ACK and DATA)
//   d          done strobe (DONE)
//   r          elapsed-cycle counter, cleared for ACK, saturating
//   data_out   last captured data beat, held between transactions
//   busy       high in every state except IDLE
//   timeout    one-cycle grant-timeout pulse (occurs in IDLE)
//
// All outputs are flops. The strobes are loaded from the next-state value so
// they line up with the state they belong to while still having no
// combinational path from any input.
// -----------------------------------------------------------------------------
module hs_txn_gen #(
  parameter int DW         = 8,
  parameter int MAX_WAIT   = 5,
  parameter int DATA_BEATS = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_req,
  input  logic          gnt,
  input  logic [DW-1:0] data_in,
  output logic          a,
  output logic          b,
  output logic          c,
  output logic          d,
  output logic [31:0]   r,
  output logic [DW-1:0] data_out,
  output logic          busy,
  output logic          timeout
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_ACK      = 3'd2,
    S_DONE     = 3'd3,
    S_WAIT_GNT = 3'd4,
    S_GRANT    = 3'd5,
    S_DATA     = 3'd6
  } state_t;

  // Last index of each counted phase; counters run 0..LAST.
  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);
  localparam logic [2:0] BEAT_LAST = 3'(DATA_BEATS - 1);

  // Saturating increment: r sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      return v;
    end else begin
      return v + 32'd1;
    end
  endfunction

  state_t          state_r;
  state_t          next_s;
  logic [3:0]      wait_cnt_r;
  logic [3:0]      wait_cnt_next_s;
  logic [2:0]      beat_cnt_r;
  logic [2:0]      beat_cnt_next_s;
  logic [31:0]     r_r;
  logic [31:0]     r_next_s;
  logic [DW-1:0]   data_out_r;
  logic            timeout_s;
  logic            a_r;
  logic            b_r;
  logic            c_r;
  logic            d_r;
  logic            busy_r;
  logic            timeout_r;

  // Next-state decode; gnt is checked before the timeout limit so a grant
  // on the final wait cycle still wins.
  always_comb begin
    next_s    = state_r;
    timeout_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start_req) begin
          next_s = S_START;
        end else begin
          next_s = S_IDLE;
        end
      end
      S_START: next_s = S_ACK;
      S_ACK:   next_s = S_DONE;
      S_DONE:  next_s = S_WAIT_GNT;
      S_WAIT_GNT: begin
        if (gnt) begin
          next_s = S_GRANT;
        end else if (wait_cnt_r == WAIT_LAST) begin
          next_s    = S_IDLE;
          timeout_s = 1'b1;
        end else begin
          next_s = S_WAIT_GNT;
        end
      end
      S_GRANT: next_s = S_DATA;
      S_DATA: begin
        if (beat_cnt_r == BEAT_LAST) begin
          next_s = S_IDLE;
        end else begin
          next_s = S_DATA;
        end
      end
      default: next_s = S_IDLE;
    endcase
  end

  // Wait and beat counters only advance inside their own phase and read as
  // zero on entry to it.
  always_comb begin
    wait_cnt_next_s = 4'd0;
    beat_cnt_next_s = 3'd0;
    if (state_r == S_WAIT_GNT) begin
      wait_cnt_next_s = wait_cnt_r + 4'd1;
    end else begin
      wait_cnt_next_s = 4'd0;
    end
    if (state_r == S_DATA) begin
      beat_cnt_next_s = beat_cnt_r + 3'd1;
    end else begin
      beat_cnt_next_s = 3'd0;
    end
  end

  // Elapsed-cycle counter: cleared while leaving START so it reads 0 in ACK,
  // then advanced on every edge out of an active state, so the IDLE value
  // after a transaction equals the cycles elapsed since ACK.
  always_comb begin
    r_next_s = r_r;
    case (state_r)
      S_START:    r_next_s = 32'd0;
      S_ACK,
      S_DONE,
      S_WAIT_GNT,
      S_GRANT,
      S_DATA:     r_next_s = sat_inc(r_r);
      default:    r_next_s = r_r;
    endcase
  end

  // State, counters and r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      wait_cnt_r <= 4'd0;
      beat_cnt_r <= 3'd0;
      r_r        <= 32'd0;
    end else begin
      state_r    <= next_s;
      wait_cnt_r <= wait_cnt_next_s;
      beat_cnt_r <= beat_cnt_next_s;
      r_r        <= r_next_s;
    end
  end

  // Registered strobes, loaded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r       <= 1'b0;
      b_r       <= 1'b0;
      c_r       <= 1'b0;
      d_r       <= 1'b0;
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      a_r       <= (next_s == S_START);
      b_r       <= (next_s == S_GRANT);
      c_r       <= (next_s == S_ACK) || (next_s == S_DATA);
      d_r       <= (next_s == S_DONE);
      busy_r    <= (next_s != S_IDLE);
      timeout_r <= timeout_s;
    end
  end

  // Data capture on each DATA beat; held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_r <= '0;
    end else if (state_r == S_DATA) begin
      data_out_r <= data_in;
    end else begin
      data_out_r <= data_out_r;
    end
  end

  assign a        = a_r;
  assign b        = b_r;
  assign c        = c_r;
  assign d        = d_r;
  assign r        = r_r;
  assign data_out = data_out_r;
  assign busy     = busy_r;
  assign timeout  = timeout_r;

endmodule

// File: tb/tb_hs_txn_gen.sv
// -----------------------------------------------------------------------------
// tb_hs_txn_gen
//
// Scoreboard bench for hs_txn_gen. Each issued transaction is turned into a
// list of timed output events computed from the transaction rules (a at T+1,
// ACK at T+2, DONE at T+3, grant k cycles into the wait window, two data
// beats, return to IDLE). A negedge monitor pops one event whenever the DUT
// shows a strobe or drops busy and compares cycle, strobes, busy, r and
// data_out.
// -----------------------------------------------------------------------------
module tb_hs_txn_gen;

  localparam int DW       = 8;
  localparam int MAX_WAIT = 5;
  localparam int DB       = 2;

  logic          clk;
  logic          rst_n;
  logic          start_req;
  logic          gnt;
  logic [DW-1:0] data_in;
  logic          a;
  logic          b;
  logic          c;
  logic          d;
  logic [31:0]   r;
  logic [DW-1:0] data_out;
  logic          busy;
  logic          timeout;

  hs_txn_gen #(.DW(DW), .MAX_WAIT(MAX_WAIT), .DATA_BEATS(DB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_req (start_req),
    .gnt       (gnt),
    .data_in   (data_in),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .r         (r),
    .data_out  (data_out),
    .busy      (busy),
    .timeout   (timeout)
  );

  typedef struct {
    int          cy;
    logic [4:0]  sig;   // {a,b,c,d,timeout}
    logic        bz;
    int unsigned rv;
    logic [7:0]  dv;
  } ev_t;

  ev_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc_cnt = 0;
  bit          mon_en = 1'b0;
  logic        busy_q = 1'b0;
  logic [7:0]  exp_dout = 8'h00;
  int unsigned last_r = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index of the interval that begins at each rising edge.
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc_cnt, act, req);
    end
  endtask

  task automatic push_ev(input int cy, input logic [4:0] s, input logic bz,
                         input int unsigned rv, input logic [7:0] dv);
    ev_t e;
    e.cy = cy; e.sig = s; e.bz = bz; e.rv = rv; e.dv = dv;
    exp_q.push_back(e);
  endtask

  // Monitor: compare one scoreboard event every time the DUT presents output.
  ev_t  mev;
  logic present;
  always @(negedge clk) begin
    if (!mon_en || !rst_n) begin
      busy_q = 1'b0;
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cy < cyc_cnt) begin
        mev = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_event cycle=%0d actual=none required abcdt=%b at cycle %0d",
                 cyc_cnt, mev.sig, mev.cy);
      end
      present = a | b | c | d | timeout | (busy_q & ~busy);
      if (present) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output cycle=%0d actual abcdt=%b busy=%b required none",
                   cyc_cnt, {a, b, c, d, timeout}, busy);
        end else begin
          mev = exp_q.pop_front();
          chk("event_cycle", longint'(cyc_cnt), longint'(mev.cy));
          chk("abcdt", {a, b, c, d, timeout}, mev.sig);
          chk("busy", busy, mev.bz);
          chk("r", r, mev.rv);
          chk("data_out", data_out, mev.dv);
        end
      end
      busy_q = busy;
    end
  end

  task automatic drive(input logic sr, input logic g, input logic [7:0] dv);
    @(posedge clk);
    #1;
    start_req = sr;
    gnt       = g;
    data_in   = dv;
  endtask

  // One transaction. k >= 0: grant on wait cycle k; k < 0: no grant (timeout).
  // hold keeps start_req high while busy (ignored by the DUT).
  task automatic run_txn(input int k, input int gap, input bit hold,
                         input logic [7:0] d0, input logic [7:0] d1, input bit rnd);
    logic [7:0] bd[DB];
    int t, e, nw, cy;
    logic sr, g;
    logic [7:0] dv;
    bd[0] = rnd ? 8'($urandom) : d0;
    bd[1] = rnd ? 8'($urandom) : d1;
    for (int i = 0; i < gap; i++) drive(1'b0, 1'($urandom), 8'($urandom));
    drive(1'b1, 1'($urandom), 8'($urandom));
    t  = cyc_cnt;
    nw = (k >= 0) ? k + 1 : MAX_WAIT;
    e  = (k >= 0) ? t + 6 + k + DB : t + 4 + MAX_WAIT;
    push_ev(t + 1, 5'b10000, 1'b1, last_r, exp_dout);
    push_ev(t + 2, 5'b00100, 1'b1, 0, exp_dout);
    push_ev(t + 3, 5'b00010, 1'b1, 1, exp_dout);
    if (k >= 0) begin
      push_ev(t + 5 + k, 5'b01000, 1'b1, 32'(3 + k), exp_dout);
      for (int j = 0; j < DB; j++) begin
        cy = t + 6 + k + j;
        push_ev(cy, 5'b00100, 1'b1, 32'(cy - t - 2), (j == 0) ? exp_dout : bd[j-1]);
      end
      push_ev(e, 5'b00000, 1'b0, 32'(e - t - 2), bd[DB-1]);
      exp_dout = bd[DB-1];
    end else begin
      push_ev(e, 5'b00001, 1'b0, 32'(e - t - 2), exp_dout);
    end
    last_r = 32'(e - t - 2);
    for (int x = t + 1; x < e; x++) begin
      sr = hold ? 1'b1 : 1'($urandom);
      if (x >= t + 4 && x < t + 4 + nw) g = (k >= 0) && (x == t + 4 + k);
      else g = 1'($urandom);
      dv = 8'($urandom);
      if (k >= 0 && x >= t + 6 + k && x < t + 6 + k + DB) dv = bd[x - (t + 6 + k)];
      drive(sr, g, dv);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_abcdt"}, {a, b, c, d, timeout}, 5'b00000);
    chk({nm, "_busy"}, busy, 1'b0);
    chk({nm, "_r"}, r, 32'd0);
    chk({nm, "_data_out"}, data_out, 8'h00);
  endtask

  initial begin
    int t, k;
    rst_n     = 1'b0;
    start_req = 1'b0;
    gnt       = 1'b0;
    data_in   = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (2) drive(1'b0, 1'b0, 8'h00);

    // Directed: basic, timeout, grant on the last wait cycle, back-to-back.
    run_txn(0, 1, 1'b0, 8'hA5, 8'h3C, 1'b0);
    run_txn(-1, 2, 1'b0, 8'h00, 8'h00, 1'b0);
    run_txn(MAX_WAIT - 1, 1, 1'b0, 8'h5A, 8'hC3, 1'b0);
    for (int i = 0; i < 3; i++) run_txn(0, 0, 1'b1, 8'h00, 8'h00, 1'b1);

    // Randomized transactions.
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, MAX_WAIT);
      if (k == MAX_WAIT) k = -1;
      t = $urandom_range(0, 3);
      run_txn(k, t, (t == 0) && ($urandom_range(0, 1) == 1), 8'h00, 8'h00, 1'b1);
    end
    repeat (3) drive(1'b0, 1'b0, 8'h00);
    chk("queue_drained", exp_q.size(), 0);

    // Reset in the middle of the DATA phase.
    mon_en = 1'b0;
    drive(1'b1, 1'b0, 8'h11);
    for (int i = 1; i <= 6; i++) drive(1'b0, (i == 4), 8'h77);
    chk("pre_reset_c", c, 1'b1);
    chk("pre_reset_busy", busy, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    repeat (2) @(posedge clk);
    #3;
    rst_n    = 1'b1;
    exp_dout = 8'h00;
    last_r   = 0;
    mon_en   = 1'b1;
    for (int i = 0; i < 10; i++) drive(1'b0, 1'($urandom), 8'($urandom));
    chk_all_zero("post_reset_idle");

    // One more transaction after reset to confirm normal operation resumed.
    run_txn(1, 1, 1'b0, 8'h00, 8'h00, 1'b1);
    repeat (3) drive(1'b0, 1'b0, 8'h00);
    chk("final_queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
